sfx_arbiter: RTL and testbench

Audio source arbiter and sequencer for the Street Fighter audio path. It turns raw sound-effect request levels into fixed-length, prioritised sound-effect slots, and falls back to background music or critical-health music between them. It produces the single registered 1-bit audio line that drives the speaker pin. It sits between the tone generators (background, critical, per-effect square waves) and the top-level audio output, and replaces ad-hoc muxing.

---
 rtl/sfx_arbiter.sv | 134 +++++++++++++
 tb/tb_sfx_arbiter.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/sfx_arbiter.sv
// Sound-effect arbiter: edge-detected requests become fixed-length prioritised slots,
// with background / critical-health music filling the gaps. Single registered audio line.
module sfx_arbiter #(
  parameter int unsigned SFX_HOLD         = 25_000_000,
  parameter int unsigned HEALTH_THRESHOLD = 154
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable_audio,
  input  logic [1:0] state,
  input  logic [8:0] player1_health,
  input  logic [8:0] player2_health,
  input  logic [3:0] sfx_req,
  input  logic [3:0] sfx_tone,
  input  logic       bgm_tone,
  input  logic       critical_tone,
  output logic       audio_out,
  output logic       sfx_busy,
  output logic [1:0] active_sfx,
  output logic [3:0] pending
);

  localparam int unsigned CntW = $clog2(SFX_HOLD);
  localparam logic [CntW-1:0] CntLoad = CntW'(SFX_HOLD - 1);
  localparam logic [8:0] HealthTh = 9'(HEALTH_THRESHOLD);

  typedef enum logic {StIdle, StPlay} state_e;

  state_e          r_state, w_state_d;
  logic [CntW-1:0] r_cnt, w_cnt_d;
  logic [1:0]      r_active, w_active_d;
  logic [3:0]      r_pending, w_pending_d;
  logic [3:0]      r_req_q;
  logic            r_audio, w_audio_d;

  logic       w_flush;
  logic [3:0] w_rise;
  logic [3:0] w_clear;
  logic       w_has_pending;
  logic [1:0] w_winner;
  logic       w_critical;

  assign w_flush       = ~enable_audio | (state == 2'b01) | (state == 2'b10);
  assign w_rise        = sfx_req & ~r_req_q;
  assign w_has_pending = |r_pending;
  assign w_critical    = (player1_health <= HealthTh) | (player2_health <= HealthTh);

  // Lowest set index wins; scan from the top so the last hit is the lowest.
  always_comb begin
    w_winner = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (r_pending[i]) w_winner = 2'(i);
    end
  end

  always_comb begin
    w_state_d   = r_state;
    w_cnt_d     = r_cnt;
    w_active_d  = r_active;
    w_clear     = 4'b0000;
    w_pending_d = r_pending;
    if (w_flush) begin
      w_state_d   = StIdle;
      w_cnt_d     = '0;
      w_active_d  = 2'd0;
      w_pending_d = 4'b0000;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (w_has_pending) begin
            w_state_d  = StPlay;
            w_active_d = w_winner;
            w_cnt_d    = CntLoad;
            w_clear    = 4'b0001 << w_winner;
          end
        end
        StPlay: begin
          if (w_has_pending && (w_winner < r_active)) begin
            // Preempted effect is dropped, not requeued.
            w_active_d = w_winner;
            w_cnt_d    = CntLoad;
            w_clear    = 4'b0001 << w_winner;
          end else if (r_pending[r_active]) begin
            w_cnt_d = CntLoad;
            w_clear = 4'b0001 << r_active;
          end else if (r_cnt == '0) begin
            w_state_d  = StIdle;
            w_active_d = 2'd0;
          end else begin
            w_cnt_d = r_cnt - 1'b1;
          end
        end
        default: w_state_d = StIdle;
      endcase
      // A new rise beats a clear on the same edge.
      w_pending_d = (r_pending & ~w_clear) | w_rise;
    end
  end

  always_comb begin
    w_audio_d = 1'b0;
    if (w_flush) begin
      w_audio_d = 1'b0;
    end else if (r_state == StPlay) begin
      w_audio_d = sfx_tone[r_active];
    end else begin
      w_audio_d = w_critical ? critical_tone : bgm_tone;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= StIdle;
      r_cnt     <= '0;
      r_active  <= 2'd0;
      r_pending <= 4'b0000;
      r_req_q   <= 4'b0000;
      r_audio   <= 1'b0;
    end else begin
      r_state   <= w_state_d;
      r_cnt     <= w_cnt_d;
      r_active  <= w_active_d;
      r_pending <= w_pending_d;
      r_req_q   <= sfx_req;
      r_audio   <= w_audio_d;
    end
  end

  assign audio_out  = r_audio;
  assign sfx_busy   = (r_state == StPlay);
  assign active_sfx = r_active;
  assign pending    = r_pending;

endmodule

// File: tb/tb_sfx_arbiter.sv
// Bench for sfx_arbiter: directed scenarios plus random traffic, every cycle compared
// against a slot-level reference model.
module tb_sfx_arbiter;

  localparam int unsigned Hold = 8;
  localparam int unsigned Th   = 154;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       enable_audio;
  logic [1:0] game_state;
  logic [8:0] p1_health, p2_health;
  logic [3:0] sfx_req, sfx_tone;
  logic       bgm_tone, critical_tone;
  logic       audio_out, sfx_busy;
  logic [1:0] active_sfx;
  logic [3:0] pending;

  sfx_arbiter #(
    .SFX_HOLD        (Hold),
    .HEALTH_THRESHOLD(Th)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .enable_audio  (enable_audio),
    .state         (game_state),
    .player1_health(p1_health),
    .player2_health(p2_health),
    .sfx_req       (sfx_req),
    .sfx_tone      (sfx_tone),
    .bgm_tone      (bgm_tone),
    .critical_tone (critical_tone),
    .audio_out     (audio_out),
    .sfx_busy      (sfx_busy),
    .active_sfx    (active_sfx),
    .pending       (pending)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Model: m_left = PLAY cycles remaining in the current slot (0 means idle).
  int m_left, m_active, m_audio;
  int m_pend[4];
  int m_req[4];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_left = 0; m_active = 0; m_audio = 0;
    for (int i = 0; i < 4; i++) begin
      m_pend[i] = 0;
      m_req[i]  = 0;
    end
  endtask

  task automatic model_step();
    bit flush;
    bit crit;
    int win, clr;
    flush = !enable_audio || game_state == 2'b01 || game_state == 2'b10;
    if (flush) begin
      m_audio = 0; m_left = 0; m_active = 0;
      for (int i = 0; i < 4; i++) begin
        m_pend[i] = 0;
        m_req[i]  = sfx_req[i];
      end
    end else begin
      crit = (p1_health <= Th) || (p2_health <= Th);
      if (m_left > 0) m_audio = sfx_tone[m_active];
      else            m_audio = crit ? critical_tone : bgm_tone;
      win = -1;
      for (int i = 3; i >= 0; i--) if (m_pend[i] != 0) win = i;
      clr = -1;
      if (m_left == 0) begin
        if (win >= 0) begin m_active = win; m_left = Hold; clr = win; end
      end else if (win >= 0 && win < m_active) begin
        m_active = win; m_left = Hold; clr = win;
      end else if (m_pend[m_active] != 0) begin
        m_left = Hold; clr = m_active;
      end else if (m_left == 1) begin
        m_left = 0; m_active = 0;
      end else begin
        m_left--;
      end
      for (int i = 0; i < 4; i++) begin
        if (i == clr) m_pend[i] = 0;
        if (sfx_req[i] && m_req[i] == 0) m_pend[i] = 1;
        m_req[i] = sfx_req[i];
      end
    end
  endtask

  task automatic compare();
    int pv;
    pv = 0;
    for (int i = 0; i < 4; i++) pv += m_pend[i] << i;
    chk("busy", sfx_busy, (m_left > 0));
    chk("active", active_sfx, m_active);
    chk("pending", pending, pv);
    chk("audio", audio_out, m_audio);
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    compare();
  endtask

  task automatic flush_case(input bit use_enable);
    sfx_tone = 4'hF;
    sfx_req = 4'b0100; cycle(); cycle(); cycle();
    sfx_req = 4'b1100; cycle();
    chk("flush_pre_pend", pending, 4'b1000);
    if (use_enable) enable_audio = 1'b0; else game_state = 2'b10;
    cycle();
    chk("flush_busy", sfx_busy, 0);
    chk("flush_pend", pending, 0);
    cycle();
    chk("flush_audio", audio_out, 0);
    enable_audio = 1'b1; game_state = 2'b00;
    repeat (12) cycle();
    chk("flush_no_fire", sfx_busy, 0);
    sfx_req = 4'b0000; cycle();
  endtask

  initial begin
    rst_n = 1'b0; enable_audio = 1'b1; game_state = 2'b00;
    p1_health = 9'd200; p2_health = 9'd200;
    sfx_req = 4'b0; sfx_tone = 4'b0; bgm_tone = 1'b0; critical_tone = 1'b0;
    model_reset();
    #3;
    chk("rst_audio", audio_out, 0);
    chk("rst_busy", sfx_busy, 0);
    chk("rst_active", active_sfx, 0);
    chk("rst_pend", pending, 0);
    #9 rst_n = 1'b1;

    // Background music follows bgm_tone one cycle late.
    bgm_tone = 1'b1; cycle(); chk("bgm_hi", audio_out, 1);
    bgm_tone = 1'b0; cycle(); chk("bgm_lo", audio_out, 0);
    repeat (6) begin bgm_tone = ~bgm_tone; cycle(); end
    bgm_tone = 1'b0;

    // Held level plays exactly one slot.
    sfx_tone = 4'hF;
    sfx_req = 4'b0100; cycle();
    chk("hold_pend", pending, 4'b0100);
    cycle();
    chk("hold_busy", sfx_busy, 1);
    chk("hold_active", active_sfx, 2);
    repeat (7) cycle();
    chk("hold_last", sfx_busy, 1);
    cycle();
    chk("hold_end", sfx_busy, 0);
    repeat (30) cycle();
    chk("hold_no_retrig", sfx_busy, 0);
    sfx_req = 4'b0; cycle();

    // Preempt by bit 0 while bit 3 stays queued.
    sfx_req = 4'b0100; cycle(); cycle(); cycle(); cycle();
    sfx_req = 4'b1100; cycle();
    sfx_req = 4'b1101; cycle();
    cycle();
    chk("pre_active", active_sfx, 0);
    chk("pre_pend", pending, 4'b1000);
    repeat (8) cycle();
    chk("pre_gap", sfx_busy, 0);
    cycle();
    chk("pre_next", active_sfx, 3);
    chk("pre_next_busy", sfx_busy, 1);
    sfx_req = 4'b0; repeat (12) cycle();

    // Retrigger near the end of a slot.
    sfx_req = 4'b0010; cycle(); cycle();
    sfx_req = 4'b0000; repeat (5) cycle();
    sfx_req = 4'b0010; cycle(); cycle();
    repeat (7) cycle();
    chk("retrig_ext", sfx_busy, 1);
    cycle();
    chk("retrig_end", sfx_busy, 0);
    sfx_req = 4'b0; cycle();

    // Health threshold boundary, and effects overriding critical music.
    bgm_tone = 1'b0; critical_tone = 1'b1;
    p2_health = 9'd154; cycle(); chk("crit_154", audio_out, 1);
    p2_health = 9'd155; cycle(); chk("crit_155", audio_out, 0);
    p2_health = 9'd154; sfx_tone = 4'b0000;
    sfx_req = 4'b0001; repeat (3) cycle();
    chk("crit_override", audio_out, 0);
    sfx_req = 4'b0; repeat (10) cycle();
    p2_health = 9'd200;

    flush_case(1'b0);
    flush_case(1'b1);

    // Asynchronous reset mid-slot.
    sfx_tone = 4'hF;
    sfx_req = 4'b0001; cycle(); cycle(); cycle();
    chk("arst_pre", audio_out, 1);
    rst_n = 1'b0; sfx_req = 4'b0;
    #2;
    chk("arst_audio", audio_out, 0);
    chk("arst_busy", sfx_busy, 0);
    chk("arst_active", active_sfx, 0);
    chk("arst_pend", pending, 0);
    model_reset();
    #2 rst_n = 1'b1;
    cycle();

    // Random traffic.
    for (int n = 0; n < 4000; n++) begin
      for (int b = 0; b < 4; b++) begin
        if ($urandom_range(0, 11) == 0) sfx_req[b] = ~sfx_req[b];
      end
      sfx_tone      = 4'($urandom);
      bgm_tone      = 1'($urandom);
      critical_tone = 1'($urandom);
      enable_audio  = ($urandom_range(0, 199) != 0);
      game_state    = ($urandom_range(0, 99) == 0) ? 2'($urandom) : {2{1'($urandom)}};
      p1_health     = ($urandom_range(0, 9) == 0) ? 9'($urandom_range(150, 158)) : 9'd300;
      p2_health     = ($urandom_range(0, 9) == 0) ? 9'($urandom_range(150, 158)) : 9'd511;
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
